// File: rtl/game_draw_controller.sv
// rtl/game_draw_controller.sv - frame sequencer and game state for the running-man datapath
module game_draw_controller #(
    parameter logic [7:0] MAN_X       = 8'd25,
    parameter logic [6:0] GROUND_Y    = 7'd108,
    parameter logic [7:0] TREE_START  = 8'd156,
    parameter logic [7:0] SPEED       = 8'd1,
    parameter logic [6:0] JUMP_STEP   = 7'd2,
    parameter logic [3:0] JUMP_FRAMES = 4'd8,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       jump_btn,
    input  logic       crouch_btn,
    input  logic       frame_tick,
    input  logic       draw_floors_finish,
    input  logic       erase_finish,
    input  logic       draw_tree_finish,
    input  logic       draw_man_finish,
    output logic       drawing_floors,
    output logic       erase,
    output logic       draw_tree,
    output logic       draw_man,
    output logic       ld_x,
    output logic       ld_y,
    output logic       ld_man_style,
    output logic       ld_shape,
    output logic [7:0] x_in,
    output logic [6:0] y_in,
    output logic       man_style,
    output logic [1:0] top,
    output logic [1:0] mid,
    output logic [1:0] bottom,
    output logic       update,
    output logic       game_over,
    output logic [7:0] overrun_cnt
);

    typedef enum logic [3:0] {
        S_FLOORS, S_IDLE, S_WAIT, S_LOAD, S_ERASE, S_TREE, S_MAN, S_PHYS, S_OVER
    } state_t;

    localparam logic [7:0] MAN_X_END = MAN_X + 8'd6;

    state_t     state_q, state_d;
    logic [7:0] tree_x_q, tree_x_d;
    logic [6:0] y_q, y_d;
    logic       man_style_q, man_style_d;
    logic [1:0] top_q, top_d, mid_q, mid_d, bottom_q, bottom_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic       airborne_q, airborne_d;
    logic       ascending_q, ascending_d;
    logic [3:0] jump_cnt_q, jump_cnt_d;
    logic       jump_req_q, jump_req_d;
    logic       jump_prev_q, jump_prev_d;
    logic       tick_pending_q, tick_pending_d;
    logic [7:0] overrun_q, overrun_d;
    logic       game_over_q, game_over_d;

    logic [7:0] lfsr_next;
    logic [6:0] y_down;
    logic       landing;
    logic       in_window;
    logic       collision;
    logic       consume;
    logic       do_init;

    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign y_down    = y_q + JUMP_STEP;
    assign landing   = (y_down >= GROUND_Y);
    assign in_window = (tree_x_q >= MAN_X) && (tree_x_q <= MAN_X_END);
    // bottom 00/01 is a low obstacle (must be airborne); 10 is overhead (must crouch)
    assign collision = in_window && (bottom_q[1] ? man_style_q : ~airborne_q);

    // next-state: sequencing, tick bookkeeping and per-frame game physics
    always_comb begin
        state_d        = state_q;
        tree_x_d       = tree_x_q;
        y_d            = y_q;
        man_style_d    = airborne_q ? 1'b1 : ~crouch_btn;
        top_d          = top_q;
        mid_d          = mid_q;
        bottom_d       = bottom_q;
        lfsr_d         = lfsr_q;
        airborne_d     = airborne_q;
        ascending_d    = ascending_q;
        jump_cnt_d     = jump_cnt_q;
        jump_req_d     = jump_req_q;
        jump_prev_d    = jump_btn;
        tick_pending_d = tick_pending_q;
        overrun_d      = overrun_q;
        game_over_d    = game_over_q;
        consume        = 1'b0;
        do_init        = 1'b0;

        if (jump_btn && !jump_prev_q && !airborne_q && !crouch_btn) begin
            jump_req_d = 1'b1;
        end

        case (state_q)
            S_FLOORS: if (draw_floors_finish) state_d = S_IDLE;
            S_IDLE:   if (start) do_init = 1'b1;
            S_WAIT: begin
                if (tick_pending_q) begin
                    consume = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD:   state_d = S_ERASE;
            S_ERASE:  if (erase_finish) state_d = S_TREE;
            S_TREE:   if (draw_tree_finish) state_d = S_MAN;
            S_MAN:    if (draw_man_finish) state_d = S_PHYS;
            S_PHYS: begin
                jump_req_d = 1'b0;
                if (collision) begin
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end else begin
                    state_d = S_WAIT;
                    if (tree_x_q < SPEED) begin
                        tree_x_d = TREE_START;
                        lfsr_d   = lfsr_next;
                        top_d    = lfsr_next[1:0];
                        mid_d    = lfsr_next[3:2];
                        bottom_d = (lfsr_next[5:4] == 2'b11) ? 2'b10 : lfsr_next[5:4];
                    end else begin
                        tree_x_d = tree_x_q - SPEED;
                    end
                    if (!airborne_q) begin
                        if (jump_req_q) begin
                            airborne_d  = 1'b1;
                            ascending_d = 1'b1;
                            jump_cnt_d  = 4'd1;
                            y_d         = y_q - JUMP_STEP;
                        end
                    end else if (ascending_q && (jump_cnt_q != JUMP_FRAMES)) begin
                        jump_cnt_d = jump_cnt_q + 4'd1;
                        y_d        = y_q - JUMP_STEP;
                    end else begin
                        ascending_d = 1'b0;
                        if (landing) begin
                            y_d        = GROUND_Y;
                            airborne_d = 1'b0;
                        end else begin
                            y_d = y_down;
                        end
                    end
                end
            end
            S_OVER:   if (start) do_init = 1'b1;
            default:  state_d = S_FLOORS;
        endcase

        // ticks only matter while a game is running; elsewhere they are dropped
        if ((state_q == S_FLOORS) || (state_q == S_IDLE) || (state_q == S_OVER)) begin
            tick_pending_d = 1'b0;
        end else begin
            tick_pending_d = (tick_pending_q && !consume) || frame_tick;
            if (frame_tick && tick_pending_q && !consume && (overrun_q != 8'hFF)) begin
                overrun_d = overrun_q + 8'd1;
            end
        end

        if (do_init) begin
            tree_x_d       = TREE_START;
            y_d            = GROUND_Y;
            airborne_d     = 1'b0;
            ascending_d    = 1'b0;
            jump_cnt_d     = 4'd0;
            jump_req_d     = 1'b0;
            game_over_d    = 1'b0;
            bottom_d       = 2'b10;
            tick_pending_d = 1'b0;
            state_d        = S_LOAD;
        end
    end

    // state and game registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_FLOORS;
            tree_x_q       <= TREE_START;
            y_q            <= GROUND_Y;
            man_style_q    <= 1'b1;
            top_q          <= 2'b00;
            mid_q          <= 2'b10;
            bottom_q       <= 2'b11;
            lfsr_q         <= LFSR_SEED;
            airborne_q     <= 1'b0;
            ascending_q    <= 1'b0;
            jump_cnt_q     <= 4'd0;
            jump_req_q     <= 1'b0;
            jump_prev_q    <= 1'b0;
            tick_pending_q <= 1'b0;
            overrun_q      <= 8'd0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            tree_x_q       <= tree_x_d;
            y_q            <= y_d;
            man_style_q    <= man_style_d;
            top_q          <= top_d;
            mid_q          <= mid_d;
            bottom_q       <= bottom_d;
            lfsr_q         <= lfsr_d;
            airborne_q     <= airborne_d;
            ascending_q    <= ascending_d;
            jump_cnt_q     <= jump_cnt_d;
            jump_req_q     <= jump_req_d;
            jump_prev_q    <= jump_prev_d;
            tick_pending_q <= tick_pending_d;
            overrun_q      <= overrun_d;
            game_over_q    <= game_over_d;
        end
    end

    assign drawing_floors = (state_q == S_FLOORS);
    assign erase          = (state_q == S_ERASE);
    assign draw_tree      = (state_q == S_TREE);
    assign draw_man       = (state_q == S_MAN);
    assign ld_x           = (state_q == S_LOAD);
    assign ld_y           = (state_q == S_LOAD);
    assign ld_man_style   = (state_q == S_LOAD);
    assign ld_shape       = (state_q == S_LOAD);
    assign update         = (state_q == S_LOAD);
    assign x_in           = tree_x_q;
    assign y_in           = y_q;
    assign man_style      = man_style_q;
    assign top            = top_q;
    assign mid            = mid_q;
    assign bottom         = bottom_q;
    assign game_over      = game_over_q;
    assign overrun_cnt    = overrun_q;

endmodule

// File: tb/tb_game_draw_controller.sv
// tb/tb_game_draw_controller.sv - directed self-checking bench for game_draw_controller
module tb_game_draw_controller;

    logic clk = 1'b0;
    logic reset_n, start, jump_btn, crouch_btn, frame_tick;
    logic draw_floors_finish, erase_finish, draw_tree_finish, draw_man_finish;
    logic drawing_floors, erase, draw_tree, draw_man;
    logic ld_x, ld_y, ld_man_style, ld_shape, update, game_over, man_style;
    logic [7:0] x_in, overrun_cnt;
    logic [6:0] y_in;
    logic [1:0] top, mid, bottom;

    logic       auto_fin, hold_erase;
    logic [3:0] fin_m;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign draw_floors_finish = auto_fin ? drawing_floors : fin_m[0];
    assign erase_finish       = auto_fin ? (erase & ~hold_erase) : fin_m[1];
    assign draw_tree_finish   = auto_fin ? draw_tree : fin_m[2];
    assign draw_man_finish    = auto_fin ? draw_man : fin_m[3];

    game_draw_controller dut (
        .clk(clk), .reset_n(reset_n), .start(start), .jump_btn(jump_btn),
        .crouch_btn(crouch_btn), .frame_tick(frame_tick),
        .draw_floors_finish(draw_floors_finish), .erase_finish(erase_finish),
        .draw_tree_finish(draw_tree_finish), .draw_man_finish(draw_man_finish),
        .drawing_floors(drawing_floors), .erase(erase), .draw_tree(draw_tree),
        .draw_man(draw_man), .ld_x(ld_x), .ld_y(ld_y), .ld_man_style(ld_man_style),
        .ld_shape(ld_shape), .x_in(x_in), .y_in(y_in), .man_style(man_style),
        .top(top), .mid(mid), .bottom(bottom), .update(update),
        .game_over(game_over), .overrun_cnt(overrun_cnt)
    );

    typedef struct {
        logic j;
        logic c;
        int   y;
        logic s;
    } jvec_t;

    jvec_t      jt[20];
    logic [7:0] seq[10];

    int         m_x;
    int         m_idx;
    logic [1:0] m_top, m_mid, m_bot;

    logic       found;
    int         cap_x, cap_y;
    logic       cap_style;
    logic [1:0] cap_top, cap_mid, cap_bot;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic en_of(input int w);
        case (w)
            1:       return erase;
            2:       return draw_tree;
            default: return draw_man;
        endcase
    endfunction

    task automatic set_model_shapes(input logic [7:0] v);
        m_top = v[1:0];
        m_mid = v[3:2];
        m_bot = (v[5:4] == 2'b11) ? 2'b10 : v[5:4];
    endtask

    task automatic manual_phase(input int w, input string name);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (!en_of(w) || ($countones({drawing_floors, erase, draw_tree, draw_man}) != 1)) ok = 1'b0;
            if (k < 4) @(negedge clk);
        end
        fin_m[w] = 1'b1;
        @(negedge clk);
        fin_m[w] = 1'b0;
        check(name, ok, 1);
    endtask

    task automatic do_frame(input logic j, input logic c);
        @(negedge clk);
        jump_btn   = j;
        crouch_btn = c;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (ld_x) begin
                found     = 1'b1;
                cap_x     = x_in;
                cap_y     = y_in;
                cap_style = man_style;
                cap_top   = top;
                cap_mid   = mid;
                cap_bot   = bottom;
                break;
            end
            @(negedge clk);
        end
        if (!found) check("frame_load_seen", 0, 1);
        repeat (5) @(negedge clk);
        jump_btn = 1'b0;
    endtask

    task automatic advance_model();
        if (m_x == 0) begin
            m_x = 156;
            m_idx++;
            set_model_shapes(seq[m_idx]);
        end else begin
            m_x--;
        end
    endtask

    task automatic run_to(input int last_x, input logic c, input logic hit);
        int lx;
        int guard;
        guard = 0;
        do begin
            do_frame(1'b0, c);
            lx = m_x;
            check("run_x", cap_x, m_x);
            check("run_bottom", cap_bot, m_bot);
            check("run_game_over", game_over, (hit && lx == last_x) ? 1 : 0);
            advance_model();
            guard++;
        end while (lx != last_x && guard < 400 && found);
    endtask

    task automatic restart_game(input string tag);
        int n_ld;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_ld_x"}, ld_x, 1);
        check({tag, "_x"}, x_in, 156);
        check({tag, "_y"}, y_in, 108);
        check({tag, "_bottom"}, bottom, 2);
        check({tag, "_game_over"}, game_over, 0);
        repeat (5) @(negedge clk);
        n_ld = 0;
        for (int k = 0; k < 12; k++) begin
            if (ld_x) n_ld++;
            @(negedge clk);
        end
        check({tag, "_no_stale_frame"}, n_ld, 0);
        m_x   = 155;
        m_bot = 2'b10;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_ld;
        int  guard;
        int  extra_x;
        logic ok, c, j;

        jt[0]  = '{1'b1, 1'b0, 108, 1'b1};
        jt[1]  = '{1'b0, 1'b0, 106, 1'b1};
        jt[2]  = '{1'b1, 1'b0, 104, 1'b1};
        jt[3]  = '{1'b0, 1'b1, 102, 1'b1};
        jt[4]  = '{1'b0, 1'b0, 100, 1'b1};
        jt[5]  = '{1'b0, 1'b0,  98, 1'b1};
        jt[6]  = '{1'b0, 1'b0,  96, 1'b1};
        jt[7]  = '{1'b0, 1'b0,  94, 1'b1};
        jt[8]  = '{1'b0, 1'b0,  92, 1'b1};
        jt[9]  = '{1'b0, 1'b0,  94, 1'b1};
        jt[10] = '{1'b0, 1'b0,  96, 1'b1};
        jt[11] = '{1'b0, 1'b0,  98, 1'b1};
        jt[12] = '{1'b0, 1'b0, 100, 1'b1};
        jt[13] = '{1'b0, 1'b0, 102, 1'b1};
        jt[14] = '{1'b0, 1'b0, 104, 1'b1};
        jt[15] = '{1'b0, 1'b0, 106, 1'b1};
        jt[16] = '{1'b0, 1'b0, 108, 1'b1};
        jt[17] = '{1'b0, 1'b1, 108, 1'b0};
        jt[18] = '{1'b1, 1'b1, 108, 1'b0};
        jt[19] = '{1'b0, 1'b0, 108, 1'b1};

        seq[0] = 8'h4A; seq[1] = 8'h95; seq[2] = 8'h2A; seq[3] = 8'h54; seq[4] = 8'hA9;
        seq[5] = 8'h53; seq[6] = 8'hA7; seq[7] = 8'h4E; seq[8] = 8'h9D; seq[9] = 8'h3B;

        reset_n = 1'b0; start = 1'b0; jump_btn = 1'b0; crouch_btn = 1'b0; frame_tick = 1'b0;
        auto_fin = 1'b0; hold_erase = 1'b0; fin_m = 4'b0000;
        m_idx = -1; m_top = 2'b00; m_mid = 2'b10; m_bot = 2'b10;

        repeat (3) @(negedge clk);
        check("rst_x", x_in, 156);
        check("rst_y", y_in, 108);
        check("rst_style", man_style, 1);
        check("rst_top", top, 0);
        check("rst_mid", mid, 2);
        check("rst_bottom", bottom, 3);
        check("rst_game_over", game_over, 0);
        check("rst_overrun", overrun_cnt, 0);
        check("rst_strobes", {ld_x, ld_y, ld_man_style, ld_shape, update, erase, draw_tree, draw_man}, 0);

        reset_n = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!drawing_floors || erase || draw_tree || draw_man) ok = 1'b0;
        end
        check("floors_hold", ok, 1);
        fin_m[0] = 1'b1;
        @(negedge clk);
        fin_m[0] = 1'b0;
        check("idle_enables", {drawing_floors, erase, draw_tree, draw_man}, 0);

        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_no_load", ld_x, 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first_load_strobes", {ld_x, ld_y, ld_man_style, ld_shape, update}, 5'b11111);
        check("first_load_x", x_in, 156);
        check("first_load_y", y_in, 108);
        check("first_load_bottom", bottom, 2);
        @(negedge clk);
        check("load_one_cycle", ld_x, 0);
        manual_phase(1, "erase_phase");
        manual_phase(2, "tree_phase");
        manual_phase(3, "man_phase");
        check("phys_enables", {drawing_floors, erase, draw_tree, draw_man, ld_x}, 0);
        n_ld = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ld_x) n_ld++;
        end
        check("wait_no_tick_no_load", n_ld, 0);

        auto_fin = 1'b1;
        do_frame(1'b0, 1'b0);
        check("second_load_x", cap_x, 155);
        check("second_load_y", cap_y, 108);
        m_x = 154;

        for (int i = 0; i < 20; i++) begin
            do_frame(jt[i].j, jt[i].c);
            check("jump_x", cap_x, 154 - i);
            check("jump_y", cap_y, jt[i].y);
            check("jump_style", cap_style, jt[i].s);
        end
        m_x = 134;

        run_to(24, 1'b1, 1'b0);
        check("crouch_pass_no_over", game_over, 0);
        run_to(0, 1'b0, 1'b0);
        do_frame(1'b0, 1'b0);
        check("wrap_x", cap_x, 156);
        check("wrap_top", cap_top, 2);
        check("wrap_mid", cap_mid, 2);
        check("wrap_bottom", cap_bot, 0);
        m_x = 155;
        run_to(31, 1'b0, 1'b1);

        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        check("over_holds", game_over, 1);
        check("over_no_draw", {erase, draw_tree, draw_man, ld_x}, 0);
        restart_game("restart1");

        run_to(31, 1'b0, 1'b1);
        restart_game("restart2");

        hold_erase = 1'b1;
        do_frame(1'b0, 1'b0);
        check("overrun_frame_x", cap_x, 155);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
        @(negedge clk);
        check("erase_still_held", erase, 1);
        check("overrun_cnt", overrun_cnt, 2);
        hold_erase = 1'b0;
        n_ld = 0;
        extra_x = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ld_x) begin
                n_ld++;
                extra_x = x_in;
            end
        end
        check("overrun_extra_frames", n_ld, 1);
        check("overrun_extra_x", extra_x, 154);
        check("overrun_cnt_after", overrun_cnt, 2);
        m_x = 153;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_ld = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ld_x) n_ld++;
        end
        check("start_ignored", n_ld, 0);

        guard = 0;
        found = 1'b1;
        while (m_idx < 9 && guard < 2000 && found) begin
            c = (m_bot == 2'b10);
            j = !c && (m_x == 34);
            do_frame(j, c);
            check("surv_x", cap_x, m_x);
            check("surv_top", cap_top, m_top);
            check("surv_mid", cap_mid, m_mid);
            check("surv_bottom", cap_bot, m_bot);
            check("surv_game_over", game_over, 0);
            advance_model();
            guard++;
        end
        do_frame(1'b0, 1'b1);
        check("lfsr11_x", cap_x, 156);
        check("lfsr11_top", cap_top, 3);
        check("lfsr11_mid", cap_mid, 2);
        check("lfsr11_bottom", cap_bot, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
